am_rx: RTL and testbench

- Receive-side alignment marker lock and removal for the 40GBASE-R PCS, LANE_N 66-bit lanes.
- Sits after per-lane block lock and before lane deskew/reorder.
- For each lane it searches for a valid alignment marker and identifies which logical lane it carries.
- It then locks to the AM_GAP marker period, and flags marker blocks so downstream logic can delete them and realign lanes.

---
 rtl/am_rx.sv | 196 +++++++++++++++++++
 tb/tb_am_rx.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_rx.sv
`default_nettype none
// =====================================================================
// am_rx : per-lane 40GBASE-R alignment marker lock, id and flagging
// Rev   : 1.0
// =====================================================================
module am_rx #(
  parameter int LANE_N = 4,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int AM_GAP = 16384
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     valid_i,
  input  logic [LANE_N-1:0]        block_lock_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     valid_o,
  output logic [LANE_N*HEAD_W-1:0] head_o,
  output logic [LANE_N*DATA_W-1:0] data_o,
  output logic [LANE_N-1:0]        marker_v_o,
  output logic [LANE_N-1:0]        lane_lock_o,
  output logic [LANE_N*2-1:0]      lane_id_o,
  output logic                     all_lock_o,
  output logic                     id_err_o
);

  localparam int               CNT_W     = $clog2(AM_GAP);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(AM_GAP - 1);
  localparam logic [2:0]       BAD_LIMIT = 3'd4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_FIRST  = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  state_t                     state_q [LANE_N];
  state_t                     state_d [LANE_N];
  logic [CNT_W-1:0]           cnt_q   [LANE_N];
  logic [CNT_W-1:0]           cnt_d   [LANE_N];
  logic [2:0]                 bad_q   [LANE_N];
  logic [2:0]                 bad_d   [LANE_N];
  logic [1:0]                 id_q    [LANE_N];
  logic [1:0]                 id_d    [LANE_N];
  logic [LANE_N-1:0]          mark_q, mark_d;
  logic [LANE_N-1:0]          lock_q, lock_d;
  logic                       valid_q;
  logic [LANE_N*HEAD_W-1:0]   head_q, head_d;
  logic [LANE_N*DATA_W-1:0]   data_q, data_d;

  logic [LANE_N-1:0]          am_hit;
  logic [LANE_N*2-1:0]        am_id;

  // Marker detect: control header, known lane pattern in B0..B2, B4..B6 its complement.
  for (genvar l = 0; l < LANE_N; l++) begin : g_match
    logic [23:0] key;
    logic [23:0] inv;
    logic        known;
    assign key   = data_i[l*DATA_W +: 24];
    assign inv   = data_i[l*DATA_W + 32 +: 24];
    assign known = (key == 24'h477690) || (key == 24'hE6C4F0) ||
                   (key == 24'h9B65C5) || (key == 24'h3D79A2);
    assign am_hit[l] = (head_i[l*HEAD_W +: HEAD_W] == HEAD_W'(1)) &&
                       (inv == ~key) && known;
    assign am_id[l*2 +: 2] = (key == 24'h477690) ? 2'd0 :
                             (key == 24'hE6C4F0) ? 2'd1 :
                             (key == 24'h9B65C5) ? 2'd2 : 2'd3;
  end

  always_comb begin
    mark_d = mark_q;
    lock_d = '0;
    head_d = valid_i ? head_i : head_q;
    data_d = valid_i ? data_i : data_q;
    for (int l = 0; l < LANE_N; l++) begin
      state_d[l] = state_q[l];
      cnt_d[l]   = cnt_q[l];
      bad_d[l]   = bad_q[l];
      id_d[l]    = id_q[l];
      if (!block_lock_i[l]) begin
        state_d[l] = ST_SEARCH;
        cnt_d[l]   = '0;
        bad_d[l]   = '0;
        id_d[l]    = '0;
        mark_d[l]  = 1'b0;
      end else if (valid_i) begin
        mark_d[l] = 1'b0;
        case (state_q[l])
          ST_SEARCH: begin
            if (am_hit[l]) begin
              state_d[l] = ST_FIRST;
              id_d[l]    = am_id[l*2 +: 2];
              cnt_d[l]   = '0;
            end
          end
          ST_FIRST: begin
            if (cnt_q[l] == CNT_LAST) begin
              cnt_d[l] = '0;
              if (am_hit[l] && (am_id[l*2 +: 2] == id_q[l])) begin
                state_d[l] = ST_LOCK;
                bad_d[l]   = '0;
                mark_d[l]  = 1'b1;
              end else begin
                state_d[l] = ST_SEARCH;
                id_d[l]    = '0;
              end
            end else begin
              cnt_d[l] = cnt_q[l] + 1'b1;
            end
          end
          ST_LOCK: begin
            cnt_d[l] = cnt_q[l] + 1'b1;
            if (cnt_q[l] == CNT_LAST) begin
              // Expected slot is always flagged, even when its content is bad.
              mark_d[l] = 1'b1;
              if (am_hit[l] && (am_id[l*2 +: 2] == id_q[l])) begin
                bad_d[l] = '0;
              end else if (bad_q[l] == BAD_LIMIT - 3'd1) begin
                state_d[l] = ST_SEARCH;
                cnt_d[l]   = '0;
                bad_d[l]   = '0;
                id_d[l]    = '0;
              end else begin
                bad_d[l] = bad_q[l] + 3'd1;
              end
            end
          end
          default: begin
            state_d[l] = ST_SEARCH;
            cnt_d[l]   = '0;
            bad_d[l]   = '0;
            id_d[l]    = '0;
          end
        endcase
      end
      lock_d[l] = (state_d[l] == ST_LOCK);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int l = 0; l < LANE_N; l++) begin
        state_q[l] <= ST_SEARCH;
        cnt_q[l]   <= '0;
        bad_q[l]   <= '0;
        id_q[l]    <= '0;
      end
      mark_q  <= '0;
      lock_q  <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int l = 0; l < LANE_N; l++) begin
        state_q[l] <= state_d[l];
        cnt_q[l]   <= cnt_d[l];
        bad_q[l]   <= bad_d[l];
        id_q[l]    <= id_d[l];
      end
      mark_q  <= mark_d;
      lock_q  <= lock_d;
      valid_q <= valid_i;
      head_q  <= head_d;
      data_q  <= data_d;
    end
  end

  // Ids must be distinct and inside 0..LANE_N-1 to form a permutation.
  logic dup;
  logic in_range;
  always_comb begin
    dup      = 1'b0;
    in_range = 1'b1;
    for (int i = 0; i < LANE_N; i++) begin
      if (int'(id_q[i]) >= LANE_N) in_range = 1'b0;
      for (int j = i + 1; j < LANE_N; j++) begin
        if (id_q[i] == id_q[j]) dup = 1'b1;
      end
    end
  end

  assign all_lock_o = (&lock_q) && !dup && in_range;
  assign id_err_o   = (&lock_q) && dup;
  assign valid_o    = valid_q;
  assign head_o     = head_q;
  assign data_o     = data_q;
  assign marker_v_o = mark_q;
  assign lane_lock_o = lock_q;

  for (genvar l = 0; l < LANE_N; l++) begin : g_out
    assign lane_id_o[l*2 +: 2] = id_q[l];
  end

endmodule
`default_nettype wire

// File: tb/tb_am_rx.sv
`default_nettype none
// =====================================================================
// tb_am_rx : table-driven and randomized self-checking bench for am_rx
// Rev      : 1.0
// =====================================================================
module tb_am_rx;

  localparam int GAP = 16;
  localparam logic [11:0] C_FILL = {3'd5, 3'd5, 3'd5, 3'd5};
  localparam logic [11:0] C_ALL  = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] C_BAD2 = {3'd3, 3'd4, 3'd1, 3'd0};
  localparam logic [11:0] C_SWAP = {3'd3, 3'd2, 3'd0, 3'd1};
  localparam logic [11:0] C_DUP2 = {3'd3, 3'd2, 3'd2, 3'd2};
  localparam logic [11:0] C_F0   = {3'd3, 3'd2, 3'd1, 3'd3};

  logic         clk = 1'b0;
  logic         nreset;
  logic         valid_i;
  logic [3:0]   block_lock_i;
  logic [7:0]   head_i;
  logic [255:0] data_i;
  logic         valid_o;
  logic [7:0]   head_o;
  logic [255:0] data_o;
  logic [3:0]   marker_v_o;
  logic [3:0]   lane_lock_o;
  logic [7:0]   lane_id_o;
  logic         all_lock_o;
  logic         id_err_o;

  int n_chk = 0;
  int n_err = 0;

  am_rx #(.LANE_N(4), .HEAD_W(2), .DATA_W(64), .AM_GAP(GAP)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .valid_i      (valid_i),
    .block_lock_i (block_lock_i),
    .head_i       (head_i),
    .data_i       (data_i),
    .valid_o      (valid_o),
    .head_o       (head_o),
    .data_o       (data_o),
    .marker_v_o   (marker_v_o),
    .lane_lock_o  (lane_lock_o),
    .lane_id_o    (lane_id_o),
    .all_lock_o   (all_lock_o),
    .id_err_o     (id_err_o)
  );

  always #5 clk = ~clk;

  // Reference: anchor id per lane (-1 = none), valid blocks since anchor modulo GAP.
  int           m_anchor [4];
  int           m_since  [4];
  int           m_miss   [4];
  bit           m_lock   [4];
  bit           m_flag   [4];
  logic         m_valid;
  logic [7:0]   m_head;
  logic [255:0] m_data;

  function automatic logic [23:0] am_tab(int id);  // {B0,B1,B2}
    case (id)
      0:       return 24'h907647;
      1:       return 24'hF0C4E6;
      2:       return 24'hC5659B;
      default: return 24'hA2793D;
    endcase
  endfunction

  function automatic logic [63:0] mk_marker(int id);
    logic [23:0] t;
    logic [7:0]  b0, b1, b2;
    t  = am_tab(id);
    b0 = t[23:16];
    b1 = t[15:8];
    b2 = t[7:0];
    return {8'($urandom), ~b2, ~b1, ~b0, 8'($urandom), b2, b1, b0};
  endfunction

  function automatic int am_decode(logic [1:0] h, logic [63:0] d);
    logic [7:0] b [8];
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    if (h != 2'b01) return -1;
    if (b[4] != ~b[0] || b[5] != ~b[1] || b[6] != ~b[2]) return -1;
    for (int k = 0; k < 4; k++) if ({b[0], b[1], b[2]} == am_tab(k)) return k;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      m_anchor[l] = -1; m_since[l] = 0; m_miss[l] = 0; m_lock[l] = 0; m_flag[l] = 0;
    end
    m_valid = 0; m_head = '0; m_data = '0;
  endtask

  task automatic model_step();
    for (int l = 0; l < 4; l++) begin
      int id;
      id = am_decode(head_i[2*l +: 2], data_i[64*l +: 64]);
      if (!block_lock_i[l]) begin
        m_anchor[l] = -1; m_since[l] = 0; m_miss[l] = 0; m_lock[l] = 0; m_flag[l] = 0;
      end else if (valid_i) begin
        m_flag[l] = 0;
        if (m_anchor[l] < 0) begin
          if (id >= 0) begin m_anchor[l] = id; m_since[l] = 0; end
        end else begin
          m_since[l] = (m_since[l] + 1) % GAP;
          if (m_since[l] == 0) begin
            if (!m_lock[l]) begin
              if (id == m_anchor[l]) begin m_lock[l] = 1; m_miss[l] = 0; m_flag[l] = 1; end
              else m_anchor[l] = -1;
            end else begin
              m_flag[l] = 1;
              if (id == m_anchor[l]) m_miss[l] = 0;
              else begin
                m_miss[l]++;
                if (m_miss[l] == 4) begin m_anchor[l] = -1; m_lock[l] = 0; m_miss[l] = 0; end
              end
            end
          end
        end
      end
    end
    m_valid = valid_i;
    if (valid_i) begin m_head = head_i; m_data = data_i; end
  endtask

  task automatic model_check();
    logic [3:0] el, em;
    logic [7:0] eid;
    bit         alll;
    int         mask;
    alll = 1; mask = 0;
    for (int l = 0; l < 4; l++) begin
      el[l] = m_lock[l];
      em[l] = m_flag[l];
      eid[2*l +: 2] = (m_anchor[l] < 0) ? 2'd0 : 2'(m_anchor[l]);
      if (!m_lock[l]) alll = 0;
      else mask |= (1 << m_anchor[l]);
    end
    chk("m.valid_o", valid_o, m_valid);
    chk("m.head_o", head_o, m_head);
    chk("m.data_o", data_o, m_data);
    chk("m.marker_v_o", marker_v_o, em);
    chk("m.lane_lock_o", lane_lock_o, el);
    chk("m.lane_id_o", lane_id_o, eid);
    chk("m.all_lock_o", all_lock_o, alll && mask == 15);
    chk("m.id_err_o", id_err_o, alll && mask != 15);
  endtask

  // Lane code: 0..3 marker of that id, 4 corrupted own-lane marker (B1 flipped), 5 random block.
  task automatic drive(input logic v, input logic [3:0] bl, input logic [11:0] codes);
    valid_i = v;
    block_lock_i = bl;
    for (int l = 0; l < 4; l++) begin
      int          c;
      logic [63:0] d;
      c = int'(codes[3*l +: 3]);
      if (c < 4) begin
        d = mk_marker(c);
        head_i[2*l +: 2] = 2'b01;
      end else if (c == 4) begin
        d = mk_marker(l);
        d[15:8] = d[15:8] ^ 8'h10;
        head_i[2*l +: 2] = 2'b01;
      end else begin
        d = {$urandom, $urandom};
        head_i[2*l +: 2] = 2'($urandom);
      end
      data_i[64*l +: 64] = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    model_check();
  endtask

  task automatic marker(input logic [11:0] codes);
    drive(1'b1, 4'hF, codes);
    step();
  endtask

  // n valid filler blocks with occasional valid_i=0 gaps between them
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 4'hF, C_FILL);
        step();
      end
      drive(1'b1, 4'hF, C_FILL);
      step();
    end
  endtask

  task automatic do_reset();
    valid_i = 0; block_lock_i = 4'hF; head_i = '0; data_i = '0;
    nreset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nreset = 1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] lk, input logic [3:0] mk,
                            input logic [7:0] id, input logic al, input logic er);
    chk({tag, ".lane_lock_o"}, lane_lock_o, lk);
    chk({tag, ".marker_v_o"}, marker_v_o, mk);
    chk({tag, ".lane_id_o"}, lane_id_o, id);
    chk({tag, ".all_lock_o"}, all_lock_o, al);
    chk({tag, ".id_err_o"}, id_err_o, er);
  endtask

  task automatic run_random(input int ncyc);
    int pos;
    pos = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      logic        v;
      logic [3:0]  bl;
      logic [11:0] codes;
      int          r, ln;
      v  = ($urandom_range(0, 4) != 0);
      bl = 4'hF;
      if ($urandom_range(0, 99) == 0) begin
        ln = int'($urandom_range(0, 3));
        bl[ln] = 1'b0;
      end
      codes = C_FILL;
      if (v) begin
        if (pos % GAP == 0) begin
          for (int l = 0; l < 4; l++) begin
            r = int'($urandom_range(0, 19));
            codes[3*l +: 3] = (r < 16) ? 3'(l ^ 1) : (r < 18) ? 3'd4 : 3'($urandom_range(0, 3));
          end
        end else if ($urandom_range(0, 49) == 0) begin
          ln = int'($urandom_range(0, 3));
          codes[3*ln +: 3] = 3'($urandom_range(0, 3));
        end
        pos++;
      end
      drive(v, bl, codes);
      step();
    end
  endtask

  typedef struct {
    logic [11:0] codes;
    logic [3:0]  lock;
    logic [3:0]  mark;
    logic [7:0]  id;
    logic        all_l;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Acquisition then four consecutive bad markers on lane 2, then relock.
    vecs[0] = '{C_ALL,  4'h0, 4'h0, 8'hE4, 1'b0, 1'b0};
    vecs[1] = '{C_ALL,  4'hF, 4'hF, 8'hE4, 1'b1, 1'b0};
    vecs[2] = '{C_BAD2, 4'hF, 4'hF, 8'hE4, 1'b1, 1'b0};
    vecs[3] = '{C_BAD2, 4'hF, 4'hF, 8'hE4, 1'b1, 1'b0};
    vecs[4] = '{C_BAD2, 4'hF, 4'hF, 8'hE4, 1'b1, 1'b0};
    vecs[5] = '{C_BAD2, 4'hB, 4'hF, 8'hC4, 1'b0, 1'b0};
    vecs[6] = '{C_ALL,  4'hB, 4'hB, 8'hE4, 1'b0, 1'b0};
    vecs[7] = '{C_ALL,  4'hF, 4'hF, 8'hE4, 1'b1, 1'b0};

    do_reset();
    model_check();

    for (int i = 0; i < 8; i++) begin
      if (i > 0) fill(GAP - 1);
      marker(vecs[i].codes);
      expect_out($sformatf("vec%0d", i), vecs[i].lock, vecs[i].mark, vecs[i].id,
                 vecs[i].all_l, vecs[i].err);
    end

    // Asynchronous reset while locked, away from any clock edge
    #3;
    nreset = 0;
    #1;
    chk("arst.valid_o", valid_o, 1'b0);
    chk("arst.data_o", data_o, 256'd0);
    expect_out("arst", 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    nreset = 1;

    marker(C_SWAP);
    expect_out("swap1", 4'h0, 4'h0, 8'hE1, 1'b0, 1'b0);
    fill(GAP - 1);
    marker(C_SWAP);
    expect_out("swap2", 4'hF, 4'hF, 8'hE1, 1'b1, 1'b0);

    // Block-lock drop on lane 3 during an idle cycle
    drive(1'b0, 4'h7, C_FILL);
    step();
    chk("bldrop.lane_lock_o", lane_lock_o, 4'h7);
    chk("bldrop.lane_id_o", lane_id_o, 8'h21);
    chk("bldrop.all_lock_o", all_lock_o, 1'b0);
    fill(GAP - 1);
    marker(C_SWAP);
    expect_out("bl_m1", 4'h7, 4'h7, 8'hE1, 1'b0, 1'b0);
    fill(GAP - 1);
    marker(C_SWAP);
    expect_out("bl_m2", 4'hF, 4'hF, 8'hE1, 1'b1, 1'b0);

    do_reset();
    marker(C_DUP2);
    fill(GAP - 1);
    marker(C_DUP2);
    expect_out("dup", 4'hF, 4'hF, 8'hEA, 1'b0, 1'b1);

    // Second marker on lane 0 carries the wrong id
    do_reset();
    marker(C_ALL);
    fill(GAP - 1);
    marker(C_F0);
    expect_out("first_fail", 4'hE, 4'hE, 8'hE4, 1'b0, 1'b0);
    fill(GAP - 1);
    marker(C_ALL);
    expect_out("first_re1", 4'hE, 4'hE, 8'hE4, 1'b0, 1'b0);
    fill(GAP - 1);
    marker(C_ALL);
    expect_out("first_re2", 4'hF, 4'hF, 8'hE4, 1'b1, 1'b0);

    do_reset();
    run_random(1500);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
